// File: rtl/fpga_cfg_pkg.sv
// Shared constants and types for the tile configuration loader.
package fpga_cfg_pkg;

    // Width of one tile configuration word.
    localparam int CFG_W          = 77;
    // Bytes consumed per tile; the last byte carries the top CFG_W%8 bits plus padding.
    localparam int BYTES_PER_TILE = (CFG_W + 7) / 8;
    // Byte counter width and the width of the byte-aligned assembly buffer.
    localparam int CNT_W          = $clog2(BYTES_PER_TILE);
    localparam int ASM_W          = BYTES_PER_TILE * 8;
    // Bits of the last byte that lie beyond CFG_W and must be zero.
    localparam logic [7:0] PAD_MASK = 8'hE0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } cfg_state_t;

endpackage

// File: rtl/fpga_config_loader_assembler.sv
// Byte assembler: counts incoming bytes, places each one into its
// little-endian slot of the configuration word and flags padding violations
// on the final byte of a tile.
module cfg_byte_assembler
    import fpga_cfg_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_i,
    output logic [CFG_W-1:0] word_o,
    output logic             word_valid_o,
    output logic             pad_err_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ASM_W-1:0] asm_q, asm_d;
    logic             last_byte;

    // Next-state for the counter and the assembly buffer; word_o shows the
    // buffer including the byte being accepted so the top can latch it directly.
    always_comb begin
        asm_d     = asm_q;
        cnt_d     = cnt_q;
        last_byte = (cnt_q == CNT_W'(BYTES_PER_TILE - 1));
        if (clear_i) begin
            asm_d = '0;
            cnt_d = '0;
        end else if (byte_valid_i) begin
            for (int k = 0; k < BYTES_PER_TILE; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    asm_d[8*k +: 8] = byte_i;
                end
            end
            cnt_d = last_byte ? '0 : cnt_q + 1'b1;
        end
        word_o       = asm_d[CFG_W-1:0];
        pad_err_o    = byte_valid_i && !clear_i && last_byte && ((byte_i & PAD_MASK) != 8'h00);
        word_valid_o = byte_valid_i && !clear_i && last_byte && ((byte_i & PAD_MASK) == 8'h00);
    end

    // Counter and buffer registers; reset discards any partial word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            asm_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            asm_q <= asm_d;
        end
    end

endmodule

// File: rtl/fpga_config_loader.sv
// Configuration loader: assembles one CFG_W-bit word per tile from a byte
// stream and writes the tiles in index order over a shared bus with a
// one-hot strobe. All outputs come from registers or decoded state.
module fpga_config_loader
    import fpga_cfg_pkg::*;
#(
    parameter  int NUM_TILES = 4,
    localparam int IDX_W     = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [7:0]           din_i,
    input  logic                 din_valid_i,
    output logic                 din_ready_o,
    output logic [NUM_TILES-1:0] tile_wr_en_o,
    output logic [CFG_W-1:0]     bits_o,
    output logic [IDX_W-1:0]     tile_idx_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o
);

    cfg_state_t           state_q, state_d;
    logic [IDX_W-1:0]     tile_idx_q, tile_idx_d;
    logic [CFG_W-1:0]     bits_q, bits_d;
    logic [NUM_TILES-1:0] wr_en_q, wr_en_d;

    logic             accept;
    logic             session_start;
    logic             asm_clear;
    logic [CFG_W-1:0] asm_word;
    logic             asm_word_valid;
    logic             asm_pad_err;

    assign accept        = (state_q == ST_LOAD) && din_valid_i;
    assign session_start = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                       (state_q == ST_ERR));
    // The byte counter restarts for every tile and for every new session.
    assign asm_clear     = session_start || (state_q == ST_WRITE);

    cfg_byte_assembler u_asm (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (asm_clear),
        .byte_valid_i (accept),
        .byte_i       (din_i),
        .word_o       (asm_word),
        .word_valid_o (asm_word_valid),
        .pad_err_o    (asm_pad_err)
    );

    // Session sequencing; bus and strobe are registered so they are live
    // exactly during the WRITE cycle and zero otherwise.
    always_comb begin
        state_d    = state_q;
        tile_idx_d = tile_idx_q;
        bits_d     = '0;
        wr_en_d    = '0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) begin
                    state_d    = ST_LOAD;
                    tile_idx_d = '0;
                end
            end
            ST_LOAD: begin
                if (asm_pad_err) begin
                    state_d = ST_ERR;
                end else if (asm_word_valid) begin
                    state_d = ST_WRITE;
                    bits_d  = asm_word;
                    wr_en_d = NUM_TILES'(1) << tile_idx_q;
                end
            end
            ST_WRITE: begin
                if (tile_idx_q == IDX_W'(NUM_TILES - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d    = ST_LOAD;
                    tile_idx_d = tile_idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; asynchronous reset also cuts an in-flight strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            tile_idx_q <= '0;
            bits_q     <= '0;
            wr_en_q    <= '0;
        end else begin
            state_q    <= state_d;
            tile_idx_q <= tile_idx_d;
            bits_q     <= bits_d;
            wr_en_q    <= wr_en_d;
        end
    end

    assign din_ready_o  = (state_q == ST_LOAD);
    assign busy_o       = (state_q == ST_LOAD) || (state_q == ST_WRITE);
    assign done_o       = (state_q == ST_DONE);
    assign error_o      = (state_q == ST_ERR);
    assign tile_idx_o   = tile_idx_q;
    assign bits_o       = bits_q;
    assign tile_wr_en_o = wr_en_q;

endmodule

// File: tb/tb_fpga_config_loader.sv
// Self-checking bench for fpga_config_loader: byte streams with various
// valid patterns, checked against expected tile writes computed from the stream.
module tb_fpga_config_loader;
    import fpga_cfg_pkg::*;

    localparam int NT = 4;
    localparam int IW = 2;
    localparam int BPT = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [7:0]      din = 8'h00;
    logic            din_valid = 1'b0;
    logic            din_ready;
    logic [NT-1:0]   tile_wr_en;
    logic [CFG_W-1:0] bits;
    logic [IW-1:0]   tile_idx;
    logic            busy, done, error;

    fpga_config_loader #(.NUM_TILES(NT)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .din_i        (din),
        .din_valid_i  (din_valid),
        .din_ready_o  (din_ready),
        .tile_wr_en_o (tile_wr_en),
        .bits_o       (bits),
        .tile_idx_o   (tile_idx),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               c;
        logic [NT-1:0]    en;
        logic [CFG_W-1:0] b;
        logic [IW-1:0]    idx;
    } rec_t;

    rec_t       rec_q[$];
    int         zero_viol = 0;
    logic [7:0] stim[$];
    int         checks = 0;
    int         errors = 0;
    int         start_cyc = 0;
    bit         sess_timeout;
    int         end_rel;
    logic       end_done, end_err, end_busy;

    // Record every strobe cycle and any non-zero bus outside a strobe.
    always @(negedge clk) begin
        if (tile_wr_en != '0) begin
            rec_t r;
            r.c   = cyc;
            r.en  = tile_wr_en;
            r.b   = bits;
            r.idx = tile_idx;
            rec_q.push_back(r);
        end else if (bits != '0) begin
            zero_viol++;
        end
    end

    function automatic logic [86:0] all_outs();
        return {din_ready, tile_wr_en, bits, tile_idx, busy, done, error};
    endfunction

    task automatic push_word(input logic [79:0] w);
        for (int k = 0; k < BPT; k++) stim.push_back(w[8*k +: 8]);
    endtask

    task automatic fill_pattern();
        logic [76:0] base;
        base = 77'h0_1234_5678_9ABC_DEF0;
        stim.delete();
        for (int t = 0; t < NT; t++) push_word({3'b000, base + 77'(t)});
    endtask

    task automatic fill_random(input int bad_tile);
        logic [79:0] w;
        stim.delete();
        for (int t = 0; t < NT; t++) begin
            w = 80'({$urandom, $urandom, $urandom});
            w[79:77] = 3'b000;
            if (t == bad_tile) w[77 + $urandom_range(0, 2)] = 1'b1;
            push_word(w);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // mode 0: valid always high, 1: toggling, 2: random
    task automatic run_session(input int mode, input int restart_at);
        int  idx;
        int  n;
        bit  v;
        idx = 0;
        n = 0;
        sess_timeout = 1'b1;
        @(negedge clk);
        rec_q.delete();
        zero_viol = 0;
        start = 1'b1;
        din_valid = 1'b0;
        start_cyc = cyc;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            start = (restart_at > 0) && (n == restart_at);
            if (done || error) begin
                sess_timeout = 1'b0;
                break;
            end
            if (idx >= stim.size()) v = 1'b0;
            else if (mode == 0) v = 1'b1;
            else if (mode == 1) v = n[0];
            else v = 1'($urandom_range(0, 1));
            din_valid = v;
            din = v ? stim[idx] : 8'($urandom);
            if (v && din_ready) idx++;
        end
        end_rel = cyc - start_cyc;
        end_done = done;
        end_err = error;
        end_busy = busy;
        din_valid = 1'b0;
        start = 1'b0;
    endtask

    // Expected writes: tile t's word is its 10 bytes little-endian, truncated
    // to 77 bits; the first tile with a padding bit set stops the session.
    task automatic check_session(input string name, input bit timing);
        logic [CFG_W-1:0] exp_words[NT];
        logic [79:0]      w;
        int               exp_n;
        bit               pad;
        int               exp_end;
        exp_n = 0;
        pad = 1'b0;
        for (int t = 0; t < NT; t++) begin
            w = '0;
            for (int k = 0; k < BPT; k++) w = w | (80'(stim[BPT*t + k]) << (8*k));
            if ((stim[BPT*t + 9] & 8'hE0) != 8'h00) begin
                pad = 1'b1;
                break;
            end
            exp_words[exp_n] = w[CFG_W-1:0];
            exp_n++;
        end
        checks++;
        if (sess_timeout) begin
            errors++;
            $display("FAIL %s timeout: no done/error within budget", name);
        end
        checks++;
        if (rec_q.size() != exp_n) begin
            errors++;
            $display("FAIL %s strobe_count: got %0d expected %0d", name, rec_q.size(), exp_n);
        end
        for (int i = 0; i < exp_n && i < rec_q.size(); i++) begin
            checks++;
            if (rec_q[i].en !== (NT'(1) << i)) begin
                errors++;
                $display("FAIL %s wr_en[%0d]: got %b expected %b", name, i, rec_q[i].en, NT'(1) << i);
            end
            checks++;
            if (rec_q[i].b !== exp_words[i]) begin
                errors++;
                $display("FAIL %s bits[%0d]: got %h expected %h", name, i, rec_q[i].b, exp_words[i]);
            end
            checks++;
            if (rec_q[i].idx !== IW'(i)) begin
                errors++;
                $display("FAIL %s tile_idx[%0d]: got %0d expected %0d", name, i, rec_q[i].idx, i);
            end
            if (timing) begin
                checks++;
                if (rec_q[i].c - start_cyc != 11*(i+1)) begin
                    errors++;
                    $display("FAIL %s strobe_cycle[%0d]: got %0d expected %0d", name, i,
                             rec_q[i].c - start_cyc, 11*(i+1));
                end
            end
        end
        checks++;
        if (end_done !== !pad || end_err !== pad || end_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s final_flags: got done=%b error=%b busy=%b expected done=%b error=%b busy=0",
                     name, end_done, end_err, end_busy, !pad, pad);
        end
        if (timing) begin
            exp_end = 11*exp_n + (pad ? 10 : 0) + 1;
            checks++;
            if (end_rel != exp_end) begin
                errors++;
                $display("FAIL %s end_cycle: got %0d expected %0d", name, end_rel, exp_end);
            end
        end
        checks++;
        if (zero_viol != 0) begin
            errors++;
            $display("FAIL %s bus_zero: got %0d nonzero cycles expected 0", name, zero_viol);
        end
        $display("session %s: strobes=%0d done=%b error=%b end=%0d", name, rec_q.size(),
                 end_done, end_err, end_rel);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_values: got %h expected 0", all_outs());
        end
        rst_n = 1'b1;
        din_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = 8'($urandom);
            @(negedge clk);
            checks++;
            if (all_outs() !== '0) begin
                errors++;
                $display("FAIL idle_no_start[%0d]: got %h expected 0", i, all_outs());
            end
        end
        din_valid = 1'b0;
        $display("reset/idle checked");
    endtask

    task automatic test_basic();
        fill_pattern();
        run_session(0, 0);
        check_session("basic", 1'b1);
    endtask

    task automatic test_toggle();
        fill_pattern();
        run_session(1, 0);
        check_session("toggle", 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) begin
            fill_random(-1);
            run_session(2, 0);
            check_session("random_stall", 1'b0);
        end
        fill_random(-1);
        run_session(0, 0);
        check_session("random_full", 1'b1);
    endtask

    task automatic test_pad_error();
        fill_pattern();
        stim[2*BPT + 9] = 8'h20;
        run_session(0, 0);
        check_session("pad_tile2", 1'b1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({error, busy, din_ready, tile_idx} !== {3'b011, IW'(0)}) begin
            errors++;
            $display("FAIL restart_clears_error: got err=%b busy=%b rdy=%b idx=%0d expected 0 1 1 0",
                     error, busy, din_ready, tile_idx);
        end
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            fill_random(int'($urandom_range(0, NT-1)));
            run_session(2, 0);
            check_session("pad_random", 1'b0);
        end
    endtask

    task automatic test_reset_mid(input int nbytes, input string name);
        int idx;
        fill_random(-1);
        idx = 0;
        @(negedge clk);
        start = 1'b1;
        din_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 200 && idx < nbytes; n++) begin
            din_valid = 1'b1;
            din = stim[idx];
            if (din_ready) idx++;
            @(negedge clk);
        end
        din_valid = 1'b0;
        checks++;
        if (nbytes == BPT) begin
            if (tile_wr_en !== 4'b0001) begin
                errors++;
                $display("FAIL %s pre_strobe: got %b expected 0001", name, tile_wr_en);
            end
        end else if ({busy, tile_idx} !== {1'b1, IW'(1)}) begin
            errors++;
            $display("FAIL %s pre_state: got busy=%b idx=%0d expected 1 1", name, busy, tile_idx);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL %s async_reset: got %h expected 0", name, all_outs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        fill_random(-1);
        run_session(0, 0);
        check_session(name, 1'b1);
    endtask

    task automatic test_start_ignored();
        fill_random(-1);
        run_session(0, 5);
        check_session("start_in_load", 1'b1);
        fill_random(-1);
        run_session(0, 11);
        check_session("start_in_write", 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_random();
        test_pad_error();
        test_reset_mid(15, "reset_mid_tile1");
        test_reset_mid(BPT, "reset_in_write");
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpga_config_loader.md
# fpga_config_loader

Configuration loader for the tile array. Accepts a byte-wide bitstream over a valid/ready stream and assembles one 77-bit configuration word per tile. Writes each word into its tile through a shared `bits` bus and a one-hot `tile_wr_en` strobe, one tile at a time in index order. Sits between the external programming port and the `Tile` instances. Each tile latches `bits` on a clock edge where its write enable is high.

## Interface
- `NUM_TILES`, 4, number of tiles programmed per session (≥1)
- `CFG_W`, 77, configuration word width per tile
- `BYTES_PER_TILE`, ceil(CFG_W/8) = 10, bytes consumed per tile
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle request to begin a programming session
- `din`  in  8  bitstream byte
- `din_valid`  in  1  `din` valid
- `din_ready`  out  1  loader accepts `din` this cycle
- `tile_wr_en`  out  NUM_TILES  one-hot write strobe, bit i targets tile i
- `bits`  out  CFG_W  configuration word to tiles
- `tile_idx`  out  clog2(NUM_TILES)  tile currently being loaded
- `busy`  out  1  session in progress
- `done`  out  1  all tiles written without error
- `error`  out  1  padding violation detected; session aborted

## Operation
- FSM states: IDLE, LOAD, WRITE, DONE, ERR.
- IDLE, DONE, ERR: `start`=1 → LOAD. On this transition, clear `tile_idx`, the byte counter, the assembly register, `done` and `error`.
- LOAD:
  - `din_ready`=1.
  - A byte is accepted on a cycle where `din_valid && din_ready`.
  - Byte k (k=0..9) fills assembly bits [8k+7:8k], little-endian. Byte 9 bits [4:0] → word bits [76:72].
  - Byte 9 bits [7:5] are padding and must be 0. If any is set: go to ERR, set `error`=1, no write for that tile.
  - After byte 9 is accepted cleanly → WRITE.
- WRITE (exactly one cycle):
  - `tile_wr_en[tile_idx]`=1, `bits`=assembled word, `din_ready`=0.
  - Next state: if `tile_idx`==NUM_TILES-1 → DONE, else increment `tile_idx`, clear the byte counter, → LOAD.
- DONE: `done`=1 and `busy`=0, held until the next `start`.
- ERR: `error`=1 and `busy`=0, held until the next `start`. Tiles written before the error keep their configuration.
- `start` in LOAD or WRITE is ignored.
- `bits`=0 and `tile_wr_en`=0 in every cycle other than WRITE. Tiles therefore see a zero bus while not being written.
- `busy`=1 in LOAD and WRITE only.

## Timing
- Reset values: state IDLE, `din_ready`=0, `tile_wr_en`=0, `bits`=0, `tile_idx`=0, `busy`=0, `done`=0, `error`=0.
- All outputs are registered or decoded from registered state only. No combinational path from `din`/`din_valid`/`start` to any output.
- `start` sampled at edge t → LOAD and `din_ready`=1 from cycle t+1.
- Last byte accepted at edge t → `tile_wr_en` and `bits` valid for the cycle after t, exactly one cycle wide.
- Minimum session length: NUM_TILES×(10+1) cycles after the start cycle, when `din_valid` is held high.
- `din_valid` stalls: the byte counter holds, and no timeout applies.
- Last tile's WRITE at cycle w → `done`=1 from cycle w+1.
- `rst_n` deasserted mid-session: immediate return to reset values, with partial assembly discarded. A strobe in flight is cut, so the tile sees no edge with `wr_en`=1 once reset is asserted.
- `din_valid`=1 outside LOAD: no byte is consumed.

## Structure
- Package `fpga_cfg_pkg`: `CFG_W`, `BYTES_PER_TILE`, the FSM state enum `cfg_state_t`, and the padding mask constant (byte 9 mask 8'hE0).
- A single module is sufficient. An optional sub-module `cfg_byte_assembler` holds the byte counter, the assembly shift/insert and the padding check, with outputs `word`, `word_valid` and `pad_err`.

## Test plan
- Reset then idle, with `din_valid`=1 and no `start` → `din_ready`=0, all outputs 0, no bytes consumed.
- `start`, then 40 contiguous bytes for NUM_TILES=4, tile i word = 77'h0_1234_5678_9ABC_DEF0 + i → four one-cycle strobes at cycles 11, 22, 33, 44 after the start cycle, with `tile_wr_en` 0001/0010/0100/1000 and `bits` matching. `done`=1 at cycle 45.
- Same stream with `din_valid` toggled every other cycle → identical words and strobe order, each strobe one cycle wide, `bits`=0 between strobes.
- Tile 2's byte 9 = 8'h20 → tiles 0 and 1 written, no strobe for tiles 2 and 3, `error`=1, `busy`=0. A new `start` then clears `error`.
- Assert `rst_n`=0 after 5 bytes of tile 1 → all outputs return to reset values asynchronously. A new session after release rewrites from tile 0.
- `start` pulsed during LOAD → ignored: `tile_idx` and the byte counter are unchanged, and the session completes normally.
